// File: rtl/free_list_pkg.sv
// ============================================================================
// Module  : riscv (package)
// Brief   : Shared rename-stage widths and the physical register tag type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv;
    localparam int FRONTEND_WIDTH      = 2;
    localparam int COMMIT_WIDTH        = 2;
    localparam int NB_PHYS_REGS        = 64;
    localparam int NB_ARCH_REGS        = 32;
    localparam int PHYS_REGS_ADDR_SIZE = $clog2(NB_PHYS_REGS);

    typedef logic [PHYS_REGS_ADDR_SIZE-1:0] preg_t;
endpackage

`default_nettype wire

// File: rtl/free_list_popcount_prefix.sv
// ============================================================================
// Module  : popcount_prefix
// Brief   : Per-bit exclusive prefix population counts plus the vector total.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount_prefix #(
    parameter int N  = 2,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]         i_vec,
    output logic [N-1:0][CW-1:0] o_prefix,
    output logic [CW-1:0]        o_total
);

    always_comb begin
        o_total = '0;
        for (int i = 0; i < N; i++) begin
            o_prefix[i] = o_total;
            o_total     = o_total + CW'(i_vec[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/free_list.sv
// ============================================================================
// Module  : free_list
// Brief   : R10K-style circular physical register free list feeding rename.
//           Define FREELIST_ASSERT_EN for SVA checks and the fl_error_o flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module free_list
    import riscv::*;
(
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic  [FRONTEND_WIDTH-1:0]           alloc_req_i,
    output logic                                 alloc_ready_o,
    output preg_t [FRONTEND_WIDTH-1:0]           freelist_preg_o,
    input  logic  [COMMIT_WIDTH-1:0]             commit_v_i,
    input  logic  [COMMIT_WIDTH-1:0]             release_v_i,
    input  preg_t [COMMIT_WIDTH-1:0]             release_preg_i,
    input  logic                                 flush_i
`ifdef FREELIST_ASSERT_EN
    ,
    output logic                                 fl_error_o
`endif
);

    // FL_DEPTH is a power of two, so pointer arithmetic wraps for free.
    localparam int FL_DEPTH = NB_PHYS_REGS - NB_ARCH_REGS;
    localparam int IDX_W    = $clog2(FL_DEPTH);
    localparam int PTR_W    = IDX_W + 1;
    localparam int FCW      = $clog2(FRONTEND_WIDTH + 1);
    localparam int CCW      = $clog2(COMMIT_WIDTH + 1);

    preg_t                           r_entry [FL_DEPTH];
    logic [PTR_W-1:0]                r_spec_head;
    logic [PTR_W-1:0]                r_commit_head;
    logic [PTR_W-1:0]                r_tail;

    logic [FRONTEND_WIDTH-1:0][FCW-1:0] w_alloc_pfx;
    logic [FCW-1:0]                     w_n_req;
    logic [COMMIT_WIDTH-1:0][CCW-1:0]   w_rel_pfx;
    logic [CCW-1:0]                     w_n_rel;
    logic [COMMIT_WIDTH-1:0][CCW-1:0]   w_cmt_pfx;
    logic [CCW-1:0]                     w_n_cmt;
    logic [PTR_W-1:0]                   w_count;
    logic [PTR_W-1:0]                   w_commit_head_next;
    logic                               w_grant;

    popcount_prefix #(.N(FRONTEND_WIDTH)) u_alloc_pc (
        .i_vec    (alloc_req_i),
        .o_prefix (w_alloc_pfx),
        .o_total  (w_n_req)
    );

    popcount_prefix #(.N(COMMIT_WIDTH)) u_rel_pc (
        .i_vec    (release_v_i),
        .o_prefix (w_rel_pfx),
        .o_total  (w_n_rel)
    );

    popcount_prefix #(.N(COMMIT_WIDTH)) u_cmt_pc (
        .i_vec    (commit_v_i),
        .o_prefix (w_cmt_pfx),
        .o_total  (w_n_cmt)
    );

    assign w_count            = r_tail - r_spec_head;
    assign alloc_ready_o      = (w_count >= PTR_W'(w_n_req));
    assign w_commit_head_next = r_commit_head + PTR_W'(w_n_cmt);
    // Grants are all-or-nothing, dropped on flush and forced to zero in reset.
    assign w_grant            = alloc_ready_o && !flush_i && reset_n;

    for (genvar gi = 0; gi < FRONTEND_WIDTH; gi++) begin : g_lane
        logic [IDX_W-1:0] w_idx;
        assign w_idx = r_spec_head[IDX_W-1:0] + IDX_W'(w_alloc_pfx[gi]);
        assign freelist_preg_o[gi] = (w_grant && alloc_req_i[gi]) ? r_entry[w_idx] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_spec_head   <= '0;
            r_commit_head <= '0;
            r_tail        <= {1'b1, {IDX_W{1'b0}}};
            for (int k = 0; k < FL_DEPTH; k++) begin
                r_entry[k] <= preg_t'(NB_ARCH_REGS + k);
            end
        end else begin
            r_commit_head <= w_commit_head_next;
            r_tail        <= r_tail + PTR_W'(w_n_rel);
            if (flush_i) begin
                r_spec_head <= w_commit_head_next;
            end else if (alloc_ready_o) begin
                r_spec_head <= r_spec_head + PTR_W'(w_n_req);
            end
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (release_v_i[j]) begin
                    r_entry[r_tail[IDX_W-1:0] + IDX_W'(w_rel_pfx[j])] <= release_preg_i[j];
                end
            end
        end
    end

`ifdef FREELIST_ASSERT_EN
    localparam int EW = PTR_W + 1;

    logic w_err_overflow;
    logic w_err_commit;
    logic w_err_x0;
    logic r_fl_error;

    assign w_err_overflow = ({1'b0, w_count} + EW'(w_n_rel)) > EW'(FL_DEPTH);
    // Commit is ahead of speculation when the modular distance goes "negative".
    assign w_err_commit   = (r_spec_head - w_commit_head_next) > PTR_W'(FL_DEPTH);

    always_comb begin
        w_err_x0 = 1'b0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (release_v_i[j] && (release_preg_i[j] == '0)) begin
                w_err_x0 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fl_error <= 1'b0;
        end else begin
            r_fl_error <= r_fl_error | w_err_overflow | w_err_commit | w_err_x0;
        end
    end

    assign fl_error_o = r_fl_error;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !w_err_overflow);
    a_commit_order: assert property (@(posedge clk) disable iff (!reset_n) !w_err_commit);
    a_no_x0_release: assert property (@(posedge clk) disable iff (!reset_n) !w_err_x0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_free_list.sv
// ============================================================================
// Module  : tb_free_list
// Brief   : Directed self-checking bench for the rename free list.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_free_list;

    logic             clk;
    logic             reset_n;
    logic [1:0]       alloc_req_i;
    logic             alloc_ready_o;
    logic [1:0][5:0]  freelist_preg_o;
    logic [1:0]       commit_v_i;
    logic [1:0]       release_v_i;
    logic [1:0][5:0]  release_preg_i;
    logic             flush_i;

    int n_tests;
    int n_fail;
    int tag_k;
    int sb[$];

    free_list u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .alloc_req_i     (alloc_req_i),
        .alloc_ready_o   (alloc_ready_o),
        .freelist_preg_o (freelist_preg_o),
        .commit_v_i      (commit_v_i),
        .release_v_i     (release_v_i),
        .release_preg_i  (release_preg_i),
        .flush_i         (flush_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alloc_req_i    = '0;
        commit_v_i     = '0;
        release_v_i    = '0;
        release_preg_i = '0;
        flush_i        = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic apply_reset();
        clear_inputs();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    function automatic int next_tag();
        next_tag = 32 + (tag_k % 32);
        tag_k++;
    endfunction

    initial begin
        int e0, e1, t0, t1;
        n_tests = 0;
        n_fail  = 0;
        tag_k   = 0;
        clear_inputs();
        reset_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_ready", alloc_ready_o, 1);
        check("rst_preg", freelist_preg_o, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        alloc_req_i = 2'b11;
        #1;
        check("init_grant", freelist_preg_o, {6'd33, 6'd32});
        check("init_ready", alloc_ready_o, 1);
        tick();
        #1;
        check("second_grant", freelist_preg_o, {6'd35, 6'd34});

        // Drain to empty
        tick();
        apply_reset();
        alloc_req_i = 2'b11;
        repeat (15) tick();
        alloc_req_i = 2'b01;
        #1;
        check("drain_31st", freelist_preg_o, {6'd0, 6'd62});
        tick();
        alloc_req_i = 2'b11;
        #1;
        check("short_ready", alloc_ready_o, 0);
        check("short_preg", freelist_preg_o, 0);
        tick();
        alloc_req_i = 2'b01;
        #1;
        check("last_grant", freelist_preg_o, {6'd0, 6'd63});
        tick();
        release_v_i    = 2'b01;
        release_preg_i = {6'd0, 6'd40};
        #1;
        check("empty_ready", alloc_ready_o, 0);
        check("no_bypass", freelist_preg_o, 0);
        tick();
        release_v_i = 2'b00;
        #1;
        check("released_40", freelist_preg_o, {6'd0, 6'd40});

        // Simultaneous alloc/release at count=1
        tick();
        alloc_req_i    = 2'b00;
        release_v_i    = 2'b01;
        release_preg_i = {6'd0, 6'd45};
        tick();
        alloc_req_i    = 2'b11;
        release_preg_i = {6'd0, 6'd50};
        #1;
        check("sim_ready", alloc_ready_o, 0);
        check("sim_preg", freelist_preg_o, 0);
        tick();
        release_v_i = 2'b00;
        #1;
        check("sim_grant", freelist_preg_o, {6'd50, 6'd45});
        check("sim_ready2", alloc_ready_o, 1);

        // Wrap-around with a release-order scoreboard
        tick();
        alloc_req_i = 2'b00;
        t0 = next_tag();
        t1 = next_tag();
        release_v_i    = 2'b11;
        release_preg_i = {t1[5:0], t0[5:0]};
        sb.push_back(t0);
        sb.push_back(t1);
        for (int c = 0; c < 96; c++) begin
            tick();
            alloc_req_i = 2'b11;
            e0 = sb.pop_front();
            e1 = sb.pop_front();
            #1;
            check("wrap_grant", freelist_preg_o, (e1 << 6) | e0);
            t0 = next_tag();
            t1 = next_tag();
            release_preg_i = {t1[5:0], t0[5:0]};
            sb.push_back(t0);
            sb.push_back(t1);
        end
        tick();
        release_v_i = 2'b00;
        e0 = sb.pop_front();
        e1 = sb.pop_front();
        #1;
        check("wrap_final", freelist_preg_o, (e1 << 6) | e0);

        // Flush restores to the committed pointer
        tick();
        apply_reset();
        alloc_req_i = 2'b11;
        repeat (3) tick();
        alloc_req_i = 2'b00;
        commit_v_i  = 2'b11;
        tick();
        commit_v_i  = 2'b00;
        flush_i     = 1'b1;
        alloc_req_i = 2'b11;
        #1;
        check("flush_nogrant", freelist_preg_o, 0);
        check("flush_ready", alloc_ready_o, 1);
        tick();
        flush_i = 1'b0;
        #1;
        check("flush_regrant", freelist_preg_o, {6'd35, 6'd34});

        // Reset asserted mid-operation with five entries left
        tick();
        apply_reset();
        alloc_req_i = 2'b11;
        repeat (13) tick();
        alloc_req_i = 2'b01;
        tick();
        alloc_req_i = 2'b11;
        reset_n = 1'b0;
        #1;
        check("midrst_ready", alloc_ready_o, 1);
        check("midrst_preg", freelist_preg_o, 0);
        reset_n = 1'b1;
        #1;
        check("midrst_grant", freelist_preg_o, {6'd33, 6'd32});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
